bus_router: RTL and testbench

BUS_ROUTER -- requirements
Module: bus_router

---
 rtl/bus_router.sv | 156 +++++++++++++++
 tb/tb_bus_router.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_router.sv
// rtl/bus_router.sv - round-robin single-bus router from NSRC sources to NDST registered destinations
//
// Ports:
//   clk, reset     : single clock, synchronous active-high reset
//   enable         : when low no new transfer is granted; destinations still drain
//   src_valid      : per-source request
//   src_data       : source i word at [i*WIDTH +: WIDTH]
//   src_dest       : source i destination index at [i*DW +: DW]
//   src_ready      : one-hot-or-zero grant (combinational)
//   dst_valid      : destination register holds a word
//   dst_data       : destination j word at [j*WIDTH +: WIDTH]
//   dst_ready      : destination j consumes when dst_valid[j] & dst_ready[j]
//   xfer_count     : saturating count of transfers delivered to a destination
//   drop_count     : saturating count of transfers discarded (index >= NDST)
module bus_router #(
    parameter int WIDTH = 4,
    parameter int NSRC  = 4,
    parameter int NDST  = 4,
    localparam int DW   = (NDST > 1) ? $clog2(NDST) : 1,
    localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC*DW-1:0]    src_dest,
    output logic [NSRC-1:0]       src_ready,
    output logic [NDST-1:0]       dst_valid,
    output logic [NDST*WIDTH-1:0] dst_data,
    input  logic [NDST-1:0]       dst_ready,
    output logic [15:0]           xfer_count,
    output logic [15:0]           drop_count
);

    logic [NDST-1:0]       dst_valid_q, dst_valid_d;
    logic [NDST*WIDTH-1:0] dst_data_q,  dst_data_d;
    logic [SW-1:0]         rr_ptr_q,    rr_ptr_d;
    logic [15:0]           xfer_count_q, xfer_count_d;
    logic [15:0]           drop_count_q, drop_count_d;

    logic [NSRC-1:0]  elig;
    logic [NSRC-1:0]  elig_rot;
    logic [NSRC-1:0]  gnt;
    logic [DW-1:0]    dest_i;
    logic             dest_ok;
    logic             found;
    int               gnt_pos;
    int               gnt_idx;
    logic [WIDTH-1:0] gnt_word;
    logic [DW-1:0]    gnt_dest;
    logic             gnt_drop;

    // Eligibility: an out-of-range index is always accepted (it is dropped);
    // an in-range destination must be empty or draining on this edge.
    always_comb begin
        elig    = '0;
        dest_i  = '0;
        dest_ok = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            dest_i  = src_dest[i*DW +: DW];
            dest_ok = (int'(dest_i) >= NDST);
            for (int j = 0; j < NDST; j++) begin
                if (int'(dest_i) == j && (!dst_valid_q[j] || dst_ready[j])) begin
                    dest_ok = 1'b1;
                end
            end
            elig[i] = enable & ~reset & src_valid[i] & dest_ok;
        end
    end

    // Round-robin: rotate the eligibility vector so bit 0 is the source at
    // rr_ptr, take the lowest set bit, then rotate the position back.
    always_comb begin
        elig_rot = NSRC'({elig, elig} >> rr_ptr_q);
        found    = 1'b0;
        gnt_pos  = 0;
        for (int k = 0; k < NSRC; k++) begin
            if (!found && elig_rot[k]) begin
                found   = 1'b1;
                gnt_pos = k;
            end
        end
        gnt_idx = gnt_pos + int'(rr_ptr_q);
        if (gnt_idx >= NSRC) begin
            gnt_idx = gnt_idx - NSRC;
        end
        gnt = '0;
        for (int i = 0; i < NSRC; i++) begin
            gnt[i] = found && (gnt_idx == i);
        end
    end

    // Mux the granted source onto the shared bus.
    always_comb begin
        gnt_word = '0;
        gnt_dest = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt[i]) begin
                gnt_word = src_data[i*WIDTH +: WIDTH];
                gnt_dest = src_dest[i*DW +: DW];
            end
        end
        gnt_drop = (int'(gnt_dest) >= NDST);
    end

    always_comb begin
        dst_valid_d  = dst_valid_q & ~dst_ready;
        dst_data_d   = dst_data_q;
        rr_ptr_d     = rr_ptr_q;
        xfer_count_d = xfer_count_q;
        drop_count_d = drop_count_q;
        if (found) begin
            rr_ptr_d = (gnt_idx == NSRC - 1) ? '0 : SW'(gnt_idx + 1);
            if (gnt_drop) begin
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
            end else begin
                if (xfer_count_q != 16'hFFFF) begin
                    xfer_count_d = xfer_count_q + 16'd1;
                end
            end
        end
        // A load overrides a same-cycle drain, giving back-to-back words.
        for (int j = 0; j < NDST; j++) begin
            if (found && !gnt_drop && int'(gnt_dest) == j) begin
                dst_valid_d[j]               = 1'b1;
                dst_data_d[j*WIDTH +: WIDTH] = gnt_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_valid_q  <= '0;
            dst_data_q   <= '0;
            rr_ptr_q     <= '0;
            xfer_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            dst_valid_q  <= dst_valid_d;
            dst_data_q   <= dst_data_d;
            rr_ptr_q     <= rr_ptr_d;
            xfer_count_q <= xfer_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign src_ready  = gnt;
    assign dst_valid  = dst_valid_q;
    assign dst_data   = dst_data_q;
    assign xfer_count = xfer_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_bus_router.sv
// tb/tb_bus_router.sv - self-checking bench for bus_router (NDST=4 and NDST=3 instances)
module tb_bus_router;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  src_valid;
    logic [15:0] src_data;
    logic [7:0]  src_dest;
    logic [3:0]  dst_ready;

    logic [3:0]  src_ready4, dst_valid4;
    logic [15:0] dst_data4, xfer4, drop4;
    logic [3:0]  src_ready3;
    logic [2:0]  dst_valid3;
    logic [11:0] dst_data3;
    logic [15:0] xfer3, drop3;

    int checks   = 0;
    int failures = 0;

    bus_router #(.WIDTH(4), .NSRC(4), .NDST(4)) u_dut4 (
        .clk(clk), .reset(reset), .enable(enable),
        .src_valid(src_valid), .src_data(src_data), .src_dest(src_dest),
        .src_ready(src_ready4), .dst_valid(dst_valid4), .dst_data(dst_data4),
        .dst_ready(dst_ready), .xfer_count(xfer4), .drop_count(drop4)
    );

    bus_router #(.WIDTH(4), .NSRC(4), .NDST(3)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable),
        .src_valid(src_valid), .src_data(src_data), .src_dest(src_dest),
        .src_ready(src_ready3), .dst_valid(dst_valid3), .dst_data(dst_data3),
        .dst_ready(dst_ready[2:0]), .xfer_count(xfer3), .drop_count(drop3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 models NDST=4, index 1 models NDST=3.
    logic       mv [2][4];
    logic [3:0] md [2][4];
    int         mptr [2];
    int         mx [2];
    int         mdr [2];
    logic [3:0] obs_rdy4;
    logic [3:0] obs_rdy3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant(input int m);
        int nd;
        int i;
        int d;
        nd = (m == 0) ? 4 : 3;
        if (reset || !enable) return -1;
        for (int k = 0; k < 4; k++) begin
            i = (mptr[m] + k) % 4;
            d = int'(src_dest[i*2 +: 2]);
            if (src_valid[i] && (d >= nd || !mv[m][d] || dst_ready[d])) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] rdy_vec(input int g);
        return (g >= 0) ? (4'b0001 << g) : 4'b0000;
    endfunction

    task automatic mupd(input int m, input int g);
        int nd;
        int d;
        nd = (m == 0) ? 4 : 3;
        if (reset) begin
            for (int j = 0; j < 4; j++) begin
                mv[m][j] = 1'b0;
                md[m][j] = 4'h0;
            end
            mptr[m] = 0;
            mx[m]   = 0;
            mdr[m]  = 0;
        end else begin
            for (int j = 0; j < nd; j++) begin
                if (mv[m][j] && dst_ready[j]) mv[m][j] = 1'b0;
            end
            if (g >= 0) begin
                d = int'(src_dest[g*2 +: 2]);
                if (d < nd) begin
                    mv[m][d] = 1'b1;
                    md[m][d] = src_data[g*4 +: 4];
                    if (mx[m] < 65535) mx[m]++;
                end else begin
                    if (mdr[m] < 65535) mdr[m]++;
                end
                mptr[m] = (g + 1) % 4;
            end
        end
    endtask

    // One clock: check grants before the edge, advance model, check state after.
    task automatic step(input string tag);
        int g0;
        int g1;
        logic [3:0]  ev4;
        logic [15:0] ed4;
        logic [2:0]  ev3;
        logic [11:0] ed3;
        g0 = exp_grant(0);
        g1 = exp_grant(1);
        #1;
        obs_rdy4 = src_ready4;
        obs_rdy3 = src_ready3;
        chk($sformatf("%s_rdy4", tag), src_ready4, rdy_vec(g0));
        chk($sformatf("%s_rdy3", tag), src_ready3, rdy_vec(g1));
        @(posedge clk);
        mupd(0, g0);
        mupd(1, g1);
        #1;
        for (int j = 0; j < 4; j++) begin
            ev4[j]       = mv[0][j];
            ed4[j*4 +: 4] = md[0][j];
        end
        for (int j = 0; j < 3; j++) begin
            ev3[j]       = mv[1][j];
            ed3[j*4 +: 4] = md[1][j];
        end
        chk($sformatf("%s_dv4", tag), dst_valid4, ev4);
        chk($sformatf("%s_dd4", tag), dst_data4, ed4);
        chk($sformatf("%s_xf4", tag), xfer4, 16'(mx[0]));
        chk($sformatf("%s_dr4", tag), drop4, 16'(mdr[0]));
        chk($sformatf("%s_dv3", tag), dst_valid3, ev3);
        chk($sformatf("%s_dd3", tag), dst_data3, ed3);
        chk($sformatf("%s_xf3", tag), xfer3, 16'(mx[1]));
        chk($sformatf("%s_dr3", tag), drop3, 16'(mdr[1]));
    endtask

    task automatic set_src(input int i, input logic v, input logic [3:0] w, input logic [1:0] d);
        src_valid[i]      = v;
        src_data[i*4 +: 4] = w;
        src_dest[i*2 +: 2] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("rst");
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        src_valid = 4'b1111;
        src_data  = 16'h1234;
        src_dest  = 8'h1B;
        dst_ready = 4'b1111;
        for (int m = 0; m < 2; m++) begin
            for (int j = 0; j < 4; j++) begin
                mv[m][j] = 1'bx;
                md[m][j] = 4'hx;
            end
        end
        // Reset with requests pending: no grants, everything cleared.
        step("rst0");
        chk("rst_dv4", dst_valid4, 4'b0000);
        chk("rst_cnt4", {xfer4, drop4}, 32'h0);
        reset     = 1'b0;
        src_valid = 4'b0000;

        // Single transfer to dest 2, destination not ready.
        set_src(0, 1'b1, 4'hA, 2'd2);
        dst_ready = 4'b0000;
        step("r29a");
        chk("r29_rdy", obs_rdy4, 4'b0001);
        chk("r29_dv", dst_valid4, 4'b0100);
        chk("r29_dd", dst_data4[11:8], 4'hA);
        chk("r29_xf", xfer4, 16'd1);
        step("r29b");
        chk("r29_block", obs_rdy4, 4'b0000);

        // Four sources, four destinations, all ready: grants 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 4'(i + 4), 2'(i));
        dst_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step("r30");
            chk($sformatf("r30_order%0d", k), obs_rdy4, 4'b0001 << (k % 4));
            chk($sformatf("r30_xf%0d", k), xfer4, 16'(k + 1));
        end

        // Move pointer to 2, then sources 1 and 3 contend for dest 0.
        do_reset();
        src_valid = 4'b0000;
        set_src(1, 1'b1, 4'h1, 2'd1);
        step("r31p");
        set_src(1, 1'b1, 4'h6, 2'd0);
        set_src(3, 1'b1, 4'h9, 2'd0);
        dst_ready = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step("r31");
            chk($sformatf("r31_order%0d", k), obs_rdy4, (k % 2 == 0) ? 4'b1000 : 4'b0010);
        end

        // Out-of-range destination on the NDST=3 instance.
        do_reset();
        src_valid = 4'b0000;
        set_src(0, 1'b1, 4'hC, 2'd3);
        dst_ready = 4'b0000;
        step("r32");
        chk("r32_rdy3", obs_rdy3, 4'b0001);
        chk("r32_dr3", drop3, 16'd1);
        chk("r32_dv3", dst_valid3, 3'b000);
        chk("r32_xf3", xfer3, 16'd0);

        // Simultaneous drain and load of dest 1, then reset mid-operation.
        do_reset();
        src_valid = 4'b0000;
        set_src(1, 1'b1, 4'h5, 2'd1);
        dst_ready = 4'b0000;
        step("r33a");
        src_valid = 4'b0000;
        set_src(2, 1'b1, 4'h9, 2'd1);
        dst_ready = 4'b0010;
        step("r33b");
        chk("r33_dv", dst_valid4[1], 1'b1);
        chk("r33_dd", dst_data4[7:4], 4'h9);
        reset = 1'b1;
        step("r33r");
        reset = 1'b0;
        chk("r33_zero", {dst_valid4, dst_data4, xfer4, drop4}, 52'h0);

        // enable low: no grants, destinations still drain.
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 4'(i + 8), 2'(i));
        dst_ready = 4'b0000;
        for (int k = 0; k < 4; k++) step("r34f");
        enable    = 1'b0;
        dst_ready = 4'b1111;
        step("r34");
        chk("r34_rdy", obs_rdy4, 4'b0000);
        chk("r34_dv", dst_valid4, 4'b0000);
        chk("r34_xf", xfer4, 16'd4);
        enable = 1'b1;

        // Counter saturation: one transfer every cycle for more than 65535 cycles.
        do_reset();
        src_valid = 4'b0000;
        set_src(0, 1'b1, 4'h3, 2'd3);
        dst_ready = 4'b1111;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_xf4", xfer4, 16'hFFFF);
        chk("sat_dr3", drop3, 16'hFFFF);
        chk("sat_xf3", xfer3, 16'd0);
        chk("sat_dr4", drop4, 16'd0);
        do_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            src_valid = 4'($urandom);
            src_data  = 16'($urandom);
            src_dest  = 8'($urandom);
            dst_ready = 4'($urandom);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
